data_cache_l1: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the MEM stage and the data memory port.
- Replaces the direct MEM-to-memory word path: serves word and sub-word loads and stores on hits, and moves 256-bit blocks to and from memory on misses.
- On a syscall flush request it writes back every dirty line and invalidates the whole cache.

---
 rtl/data_cache_l1.sv | 170 +++++++++++++++++
 tb/tb_data_cache_l1.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_l1.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 32-byte lines.
// Hits complete combinationally; misses move whole blocks; flush cleans and invalidates every line.
module data_cache_l1 #(
   parameter int NUM_LINES  = 64,
   parameter int INDEX_BITS = 6
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [31:0]  data_address_2DC,
   input  logic         read_2DC,
   input  logic         write_2DC,
   input  logic [31:0]  data_write_2DC,
   input  logic [1:0]   data_write_size_2DC,
   input  logic         flush_2DC,
   output logic [31:0]  data_read_fDC,
   output logic         data_valid_fDC,
   output logic [31:0]  data_address_2DM,
   output logic         dBlkRead,
   output logic         dBlkWrite,
   output logic [255:0] block_write_2DM,
   input  logic [255:0] block_read_fDM,
   input  logic         block_read_fDM_valid,
   input  logic         block_write_fDM_valid
);
   localparam int TAG_BITS = 32 - 5 - INDEX_BITS;

   typedef enum logic [2:0] {IDLE, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE} state_t;
   state_t stateReg, stateNext;

   logic [255:0]          lineData [NUM_LINES];
   logic [TAG_BITS-1:0]   lineTag  [NUM_LINES];
   logic [NUM_LINES-1:0]  validReg, dirtyReg;
   logic [INDEX_BITS-1:0] flushIdxReg;

   logic [INDEX_BITS-1:0] reqIndex;
   logic [TAG_BITS-1:0]   reqTag;
   logic [2:0]            wordSel;
   logic [1:0]            byteOff;
   logic [2:0]            nBytes;
   logic [255:0]          curLine, storeLine;
   logic [31:0]           curWord, mergedWord;
   logic                  reqActive, lineHit, hitNow, storeEn;

   assign reqIndex  = data_address_2DC[5 +: INDEX_BITS];
   assign reqTag    = data_address_2DC[31 -: TAG_BITS];
   assign wordSel   = data_address_2DC[4:2];
   assign byteOff   = data_address_2DC[1:0];
   assign nBytes    = (data_write_size_2DC == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DC};
   assign reqActive = read_2DC | write_2DC;
   assign curLine   = lineData[reqIndex];
   assign curWord   = curLine[32*wordSel +: 32];
   assign lineHit   = validReg[reqIndex] && (lineTag[reqIndex] == reqTag);
   assign hitNow    = (stateReg == IDLE) && !flush_2DC && reqActive && lineHit;
   assign storeEn   = hitNow && write_2DC;

   // Byte lane gi sits at address offset gi (big-endian); lanes past the word end are never selected.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [2:0] rel;
         logic [2:0] srcSel;
         logic       laneWe;
         assign rel    = 3'(gi) - {1'b0, byteOff};
         assign laneWe = (3'(gi) >= {1'b0, byteOff}) && (rel < nBytes);
         assign srcSel = nBytes - 3'd1 - rel;
         assign mergedWord[31-8*gi -: 8] = laneWe ? data_write_2DC[8*srcSel[1:0] +: 8]
                                                  : curWord[31-8*gi -: 8];
      end
   endgenerate

   always_comb begin
      storeLine = curLine;
      storeLine[32*wordSel +: 32] = mergedWord;
   end

   always_ff @(posedge CLK) begin
      if (storeEn) begin
         lineData[reqIndex] <= storeLine;
      end else if (stateReg == FILL && block_read_fDM_valid) begin
         lineData[reqIndex] <= block_read_fDM;
         lineTag[reqIndex]  <= reqTag;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         stateReg    <= IDLE;
         validReg    <= '0;
         dirtyReg    <= '0;
         flushIdxReg <= '0;
      end else begin
         stateReg <= stateNext;
         case (stateReg)
            IDLE: begin
               if (flush_2DC)    flushIdxReg <= '0;
               else if (storeEn) dirtyReg[reqIndex] <= 1'b1;
            end
            WRITEBACK: if (block_write_fDM_valid) dirtyReg[reqIndex] <= 1'b0;
            FILL: begin
               if (block_read_fDM_valid) begin
                  validReg[reqIndex] <= 1'b1;
                  dirtyReg[reqIndex] <= 1'b0;
               end
            end
            FLUSH_SCAN: begin
               if (!(validReg[flushIdxReg] && dirtyReg[flushIdxReg])) begin
                  validReg[flushIdxReg] <= 1'b0;
                  flushIdxReg           <= flushIdxReg + 1'b1;
               end
            end
            FLUSH_WB: if (block_write_fDM_valid) dirtyReg[flushIdxReg] <= 1'b0;
            default: ;
         endcase
      end
   end

   always_comb begin
      stateNext        = stateReg;
      dBlkRead         = 1'b0;
      dBlkWrite        = 1'b0;
      data_address_2DM = '0;
      block_write_2DM  = '0;
      data_valid_fDC   = 1'b0;
      data_read_fDC    = '0;
      case (stateReg)
         IDLE: begin
            if (flush_2DC) begin
               stateNext = FLUSH_SCAN;
            end else if (reqActive) begin
               if (lineHit) begin
                  data_valid_fDC = 1'b1;
                  data_read_fDC  = curWord;
               end else if (validReg[reqIndex] && dirtyReg[reqIndex]) begin
                  stateNext = WRITEBACK;
               end else begin
                  stateNext = FILL;
               end
            end
         end
         WRITEBACK: begin
            dBlkWrite        = 1'b1;
            data_address_2DM = {lineTag[reqIndex], reqIndex, 5'b0};
            block_write_2DM  = curLine;
            if (block_write_fDM_valid) stateNext = FILL;
         end
         FILL: begin
            dBlkRead         = 1'b1;
            data_address_2DM = {reqTag, reqIndex, 5'b0};
            if (block_read_fDM_valid) stateNext = IDLE;
         end
         FLUSH_SCAN: begin
            if (validReg[flushIdxReg] && dirtyReg[flushIdxReg])
               stateNext = FLUSH_WB;
            else if (flushIdxReg == INDEX_BITS'(NUM_LINES - 1))
               stateNext = FLUSH_DONE;
         end
         FLUSH_WB: begin
            dBlkWrite        = 1'b1;
            data_address_2DM = {lineTag[flushIdxReg], flushIdxReg, 5'b0};
            block_write_2DM  = lineData[flushIdxReg];
            if (block_write_fDM_valid) stateNext = FLUSH_SCAN;
         end
         FLUSH_DONE: begin
            data_valid_fDC = 1'b1;
            stateNext      = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end
endmodule

// File: tb/tb_data_cache_l1.sv
// Bench for data_cache_l1: directed vector table, flush/reset sequences, then random traffic
// checked against a flat byte-addressed memory plus a tag directory.
module tb_data_cache_l1;
   localparam int LR = 3;
   localparam int LW = 2;
   localparam int MAXLAT = 100;
   localparam int NLINES = 64;

   logic         CLK = 0;
   logic         RESET;
   logic [31:0]  data_address_2DC;
   logic         read_2DC, write_2DC;
   logic [31:0]  data_write_2DC;
   logic [1:0]   data_write_size_2DC;
   logic         flush_2DC;
   logic [31:0]  data_read_fDC;
   logic         data_valid_fDC;
   logic [31:0]  data_address_2DM;
   logic         dBlkRead, dBlkWrite;
   logic [255:0] block_write_2DM;
   logic [255:0] block_read_fDM;
   logic         block_read_fDM_valid, block_write_fDM_valid;

   data_cache_l1 #(.NUM_LINES(64), .INDEX_BITS(6)) dut (
      .CLK(CLK), .RESET(RESET),
      .data_address_2DC(data_address_2DC), .read_2DC(read_2DC), .write_2DC(write_2DC),
      .data_write_2DC(data_write_2DC), .data_write_size_2DC(data_write_size_2DC),
      .flush_2DC(flush_2DC), .data_read_fDC(data_read_fDC), .data_valid_fDC(data_valid_fDC),
      .data_address_2DM(data_address_2DM), .dBlkRead(dBlkRead), .dBlkWrite(dBlkWrite),
      .block_write_2DM(block_write_2DM), .block_read_fDM(block_read_fDM),
      .block_read_fDM_valid(block_read_fDM_valid), .block_write_fDM_valid(block_write_fDM_valid)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   logic [31:0]  memW   [int unsigned];
   logic [31:0]  refMem [int unsigned];
   logic [31:0]  wbLog[$], rdLog[$], expWb[$], expRd[$];
   logic [255:0] wbData[$];
   bit           refValid [NLINES];
   bit           refDirty [NLINES];
   int unsigned  refTag   [NLINES];
   bit           respEn = 1;
   int           rcnt, wcnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] initWord(input int unsigned wa);
      return (wa * 32'h9E3779B1) ^ 32'h5BD1E995;
   endfunction
   function automatic logic [31:0] memWord(input int unsigned wa);
      if (memW.exists(wa)) return memW[wa];
      return initWord(wa);
   endfunction
   function automatic logic [31:0] refWord(input int unsigned wa);
      if (refMem.exists(wa)) return refMem[wa];
      return initWord(wa);
   endfunction

   // Memory responder: acks a write-back after LW cycles of dBlkWrite, a fill after LR cycles of dBlkRead.
   initial begin
      block_read_fDM_valid = 0; block_write_fDM_valid = 0; block_read_fDM = '0;
      rcnt = 0; wcnt = 0;
      forever begin
         @(negedge CLK);
         block_read_fDM_valid = 0;
         block_write_fDM_valid = 0;
         if (dBlkWrite && RESET) begin
            wcnt++;
            if (wcnt >= LW) begin
               for (int k = 0; k < 8; k++)
                  memW[(data_address_2DM >> 2) + 32'(k)] = block_write_2DM[32*k +: 32];
               wbLog.push_back(data_address_2DM);
               wbData.push_back(block_write_2DM);
               block_write_fDM_valid = 1;
               wcnt = 0;
            end
         end else wcnt = 0;
         if (dBlkRead && RESET && respEn) begin
            rcnt++;
            if (rcnt >= LR) begin
               for (int k = 0; k < 8; k++)
                  block_read_fDM[32*k +: 32] = memWord((data_address_2DM >> 2) + 32'(k));
               rdLog.push_back(data_address_2DM);
               block_read_fDM_valid = 1;
               rcnt = 0;
            end
         end else rcnt = 0;
      end
   end

   // Reference: the cache is transparent, so loads see a flat memory; the directory predicts traffic.
   task automatic modelAccess(input bit isW, input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] size, output logic [31:0] rd, output int lat);
      int unsigned idx, tag;
      int n;
      idx = (addr >> 5) % NLINES;
      tag = addr >> 11;
      expWb.delete(); expRd.delete();
      lat = 0;
      if (!(refValid[idx] && refTag[idx] == tag)) begin
         lat = 1 + LR;
         if (refValid[idx] && refDirty[idx]) begin
            expWb.push_back(32'((refTag[idx] << 11) | (idx << 5)));
            lat += LW;
         end
         expRd.push_back(addr & ~32'h1F);
         refValid[idx] = 1; refTag[idx] = tag; refDirty[idx] = 0;
      end
      rd = refWord(addr >> 2);
      if (isW) begin
         n = (size == 2'd0) ? 4 : int'(size);
         for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            logic [31:0] w;
            a = addr + 32'(i);
            if (a[31:2] == addr[31:2]) begin
               w = refWord(a >> 2);
               w[8*(3 - int'(a[1:0])) +: 8] = data[8*(n - 1 - i) +: 8];
               refMem[a >> 2] = w;
            end
         end
         refDirty[idx] = 1;
      end
   endtask

   task automatic compareLogs();
      chk("wbCount", 32'(wbLog.size()), 32'(expWb.size()));
      if (wbLog.size() == expWb.size())
         foreach (expWb[i]) chk("wbAddr", wbLog[i], expWb[i]);
      chk("rdCount", 32'(rdLog.size()), 32'(expRd.size()));
      if (rdLog.size() == expRd.size())
         foreach (expRd[i]) chk("rdAddr", rdLog[i], expRd[i]);
   endtask

   task automatic runOne(input bit isW, input bit alsoRead, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] size, input bit useTbl,
                         input bit chkRead, input logic [31:0] tRead, input int tLat);
      logic [31:0] mRead, got;
      int mLat, lat;
      bit done;
      modelAccess(isW, addr, data, size, mRead, mLat);
      wbLog.delete(); rdLog.delete();
      @(posedge CLK); #1;
      data_address_2DC = addr; data_write_2DC = data; data_write_size_2DC = size;
      write_2DC = isW; read_2DC = !isW || alsoRead;
      lat = 0; got = 0; done = 0;
      while (!done && lat <= MAXLAT) begin
         @(negedge CLK); #1;
         if (data_valid_fDC) begin got = data_read_fDC; done = 1; end
         else lat++;
      end
      if (!done) chk("reqTimeout", 32'(0), 32'(1));
      @(posedge CLK); #1;
      read_2DC = 0; write_2DC = 0;
      if (!isW && chkRead) chk("loadData", got, useTbl ? tRead : mRead);
      chk("latency", 32'(lat), 32'(useTbl ? tLat : mLat));
      compareLogs();
      $display("[TB] %s addr=%h size=%0d wdata=%h rdata=%h lat=%0d", isW ? "ST" : "LD",
               addr, size, data, got, lat);
   endtask

   task automatic doFlush();
      int cyc, nd;
      bit done;
      expWb.delete(); expRd.delete();
      for (int i = 0; i < NLINES; i++) begin
         if (refValid[i] && refDirty[i]) expWb.push_back(32'((refTag[i] << 11) | (i << 5)));
         refValid[i] = 0; refDirty[i] = 0;
      end
      nd = expWb.size();
      wbLog.delete(); rdLog.delete(); wbData.delete();
      @(posedge CLK); #1 flush_2DC = 1;
      cyc = 0; done = 0;
      while (!done && cyc < 5000) begin
         @(negedge CLK); #1;
         if (data_valid_fDC) done = 1; else cyc++;
      end
      if (!done) chk("flushTimeout", 32'(0), 32'(1));
      @(posedge CLK); #1 flush_2DC = 0;
      @(negedge CLK); #1 chk("flushOnePulse", 32'(data_valid_fDC), 32'(0));
      chk("flushCycles", 32'(cyc), 32'(1 + NLINES + nd * (LW + 1)));
      compareLogs();
      $display("[TB] FLUSH writebacks=%0d cycles=%0d", wbLog.size(), cyc);
   endtask

   task automatic modelReset();
      for (int i = 0; i < NLINES; i++) begin refValid[i] = 0; refDirty[i] = 0; end
      refMem.delete();
      foreach (memW[k]) refMem[k] = memW[k];
   endtask

   typedef struct {
      bit          isW;
      bit          alsoRead;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      bit          chkRead;
      logic [31:0] expRead;
      int          expLat;
   } vec_t;
   vec_t vecs[11];

   initial begin
      logic [255:0] blk;
      vecs[0]  = '{0, 0, 32'h100,  32'h0,        2'd0, 1, 32'hDEADBEEF, 4};
      vecs[1]  = '{0, 0, 32'h100,  32'h0,        2'd0, 1, 32'hDEADBEEF, 0};
      vecs[2]  = '{1, 0, 32'h100,  32'h11223344, 2'd0, 0, 32'h0,        0};
      vecs[3]  = '{1, 1, 32'h102,  32'h000000AA, 2'd1, 0, 32'h0,        0};
      vecs[4]  = '{0, 0, 32'h100,  32'h0,        2'd0, 1, 32'h1122AA44, 0};
      vecs[5]  = '{1, 0, 32'h103,  32'h00ABCDEF, 2'd3, 0, 32'h0,        0};
      vecs[6]  = '{0, 0, 32'h100,  32'h0,        2'd0, 1, 32'h1122AAAB, 0};
      vecs[7]  = '{0, 0, 32'h2100, 32'h0,        2'd0, 1, 32'h5A5A0001, 6};
      vecs[8]  = '{0, 0, 32'h100,  32'h0,        2'd0, 1, 32'h1122AAAB, 4};
      vecs[9]  = '{1, 0, 32'h104,  32'hCAFEF00D, 2'd0, 0, 32'h0,        0};
      vecs[10] = '{0, 0, 32'h104,  32'h0,        2'd0, 1, 32'hCAFEF00D, 4};

      memW[32'h100 >> 2]  = 32'hDEADBEEF;
      memW[32'h2100 >> 2] = 32'h5A5A0001;
      modelReset();

      RESET = 0; read_2DC = 0; write_2DC = 0; flush_2DC = 0;
      data_address_2DC = 0; data_write_2DC = 0; data_write_size_2DC = 0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rstRead",  32'(dBlkRead), 32'(0));
      chk("rstWrite", 32'(dBlkWrite), 32'(0));
      chk("rstValid", 32'(data_valid_fDC), 32'(0));
      chk("rstRdata", data_read_fDC, 32'h0);
      chk("rstAddr",  data_address_2DM, 32'h0);
      chk("rstBlock", 32'(|block_write_2DM), 32'(0));
      @(negedge CLK); RESET = 1;

      for (int i = 0; i < 10; i++)
         runOne(vecs[i].isW, vecs[i].alsoRead, vecs[i].addr, vecs[i].data, vecs[i].size, 1,
                vecs[i].chkRead, vecs[i].expRead, vecs[i].expLat);
      doFlush();
      blk = (wbData.size() > 0) ? wbData[0] : '0;
      chk("flushWord1", blk[63:32], 32'hCAFEF00D);
      runOne(vecs[10].isW, vecs[10].alsoRead, vecs[10].addr, vecs[10].data, vecs[10].size, 1,
             vecs[10].chkRead, vecs[10].expRead, vecs[10].expLat);

      // Reset asserted while a fill is outstanding and memory has not answered.
      respEn = 0;
      @(posedge CLK); #1;
      data_address_2DC = 32'h3000; read_2DC = 1;
      repeat (3) @(negedge CLK);
      #1;
      chk("fillReqHeld", 32'(dBlkRead), 32'(1));
      chk("fillReqAddr", data_address_2DM, 32'h3000);
      #2 RESET = 0;
      #1 chk("rstDropsRead", 32'(dBlkRead), 32'(0));
      read_2DC = 0;
      @(posedge CLK); @(negedge CLK); #1 RESET = 1;
      respEn = 1;
      modelReset();
      $display("[TB] RESET during fill at addr=00003000");
      runOne(0, 0, 32'h3000, 32'h0, 2'd0, 0, 1, 32'h0, 0);

      for (int n = 0; n < 250; n++) begin
         if (n % 60 == 59) doFlush();
         else begin
            int unsigned r, idx, a;
            r = $urandom_range(0, 4);
            idx = (r == 4) ? 63 : r;
            a = ($urandom_range(0, 3) << 11) | (idx << 5) | ($urandom_range(0, 7) << 2)
                | $urandom_range(0, 3);
            runOne(($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), 32'(a), $urandom,
                   2'($urandom_range(0, 3)), 0, 1, 32'h0, 0);
         end
      end
      doFlush();
      foreach (refMem[k]) chk("memFinal", memWord(k), refMem[k]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
